// File: rtl/mb_cycle_ctl_if.sv
// Cache-request and motherboard-bus signal bundle for mb_cycle_ctl.
// slave: the cycle controller; master: the cache/pad environment driving it.
interface mb_cycle_ctl_if;
  logic        ReqValid;
  logic        ReqReady;
  logic [25:0] ReqCA;
  logic        ReqWrite;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspErr;
  logic [29:0] MBA;
  logic        MBRnW;
  logic        nMBAS;
  logic        nMBDS;
  logic [31:0] MBDOut;
  logic        MBDOE;
  logic [31:0] MBDIn;
  logic [1:0]  nDSACK;
  logic        nBERR;

  modport slave (
    input  ReqValid, ReqCA, ReqWrite, ReqWData, MBDIn, nDSACK, nBERR,
    output ReqReady, RspValid, RspData, RspErr,
           MBA, MBRnW, nMBAS, nMBDS, MBDOut, MBDOE
  );

  modport master (
    output ReqValid, ReqCA, ReqWrite, ReqWData, MBDIn, nDSACK, nBERR,
    input  ReqReady, RspValid, RspData, RspErr,
           MBA, MBRnW, nMBAS, nMBDS, MBDOut, MBDOE
  );
endinterface

// File: rtl/mb_cycle_ctl.sv
// Motherboard bus cycle controller: expands a compressed cache address and runs one
// asynchronous 68030-style longword cycle, returning read data or error status to the cache.
module mb_cycle_ctl #(
  parameter int unsigned TO_CYCLES = 64,
  parameter int unsigned RECOV_MIN = 1
) (
  input  logic          CLK,
  input  logic          nRES,
  mb_cycle_ctl_if.slave mb
);

  typedef enum logic [2:0] {IDLE, ADDR, STRB, RESP, WREL} state_t;

  localparam logic [7:0] TO_LAST    = 8'(TO_CYCLES - 1);
  localparam logic [3:0] RECOV_LOAD = 4'(RECOV_MIN);

  state_t      state;
  logic [1:0]  dsack_s1, dsack_s2;
  logic        berr_s1, berr_s2;
  logic [7:0]  tcnt;
  logic [3:0]  recov;

  logic [29:0] mba_q;
  logic        rnw_q;
  logic        as_n_q;
  logic        ds_n_q;
  logic [31:0] dout_q;
  logic        doe_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_data_q;

  logic        req_ready;
  logic        term_ok;
  logic        term_narrow;
  logic        timeout;
  logic        strb_exit;
  logic        strb_err;

  // CA[27:2] -> A[31:2]: A31=0, A30=CA27, A29=0, A28=CA26, A27:26=0, A25:2=CA25:2
  function automatic logic [29:0] expand(input logic [25:0] ca);
    return {1'b0, ca[25], 1'b0, ca[24], 2'b00, ca[23:0]};
  endfunction

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      dsack_s1 <= '1;
      dsack_s2 <= '1;
      berr_s1  <= 1'b1;
      berr_s2  <= 1'b1;
    end else begin
      dsack_s1 <= mb.nDSACK;
      dsack_s2 <= dsack_s1;
      berr_s1  <= mb.nBERR;
      berr_s2  <= berr_s1;
    end
  end

  // Error wins over a simultaneous full-width DSACK; any exit other than a clean 32-bit ack errs.
  always_comb begin
    term_ok     = (dsack_s2 == 2'b00);
    term_narrow = (dsack_s2 == 2'b01) || (dsack_s2 == 2'b10);
    timeout     = (tcnt == TO_LAST);
    strb_exit   = !berr_s2 || term_ok || term_narrow || timeout;
    strb_err    = !berr_s2 || !term_ok;
  end

  assign req_ready = nRES && (state == IDLE) && (recov == '0);

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state       <= IDLE;
      mba_q       <= '0;
      rnw_q       <= 1'b1;
      as_n_q      <= 1'b1;
      ds_n_q      <= 1'b1;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      tcnt        <= '0;
      recov       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (recov != '0) recov <= recov - 4'd1;
          if (mb.ReqValid && req_ready) begin
            mba_q  <= expand(mb.ReqCA);
            rnw_q  <= ~mb.ReqWrite;
            dout_q <= mb.ReqWData;
            doe_q  <= mb.ReqWrite;
            state  <= ADDR;
          end
        end
        ADDR: begin
          as_n_q <= 1'b0;
          // Writes hold DS off for the first strobe cycle.
          ds_n_q <= ~rnw_q;
          tcnt   <= '0;
          state  <= STRB;
        end
        STRB: begin
          ds_n_q <= 1'b0;
          tcnt   <= tcnt + 8'd1;
          if (strb_exit) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= strb_err;
            as_n_q      <= 1'b1;
            ds_n_q      <= 1'b1;
            doe_q       <= 1'b0;
            if (rnw_q && term_ok) rsp_data_q <= mb.MBDIn;
          end
        end
        RESP: begin
          recov <= RECOV_LOAD;
          state <= WREL;
        end
        WREL: begin
          if (recov != '0) recov <= recov - 4'd1;
          if (dsack_s2 == 2'b11 && berr_s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mb.ReqReady = req_ready;
  assign mb.RspValid = rsp_valid_q;
  assign mb.RspErr   = rsp_err_q;
  assign mb.RspData  = rsp_data_q;
  assign mb.MBA      = mba_q;
  assign mb.MBRnW    = rnw_q;
  assign mb.nMBAS    = as_n_q;
  assign mb.nMBDS    = ds_n_q;
  assign mb.MBDOut   = dout_q;
  assign mb.MBDOE    = doe_q;

endmodule

// File: tb/tb_mb_cycle_ctl.sv
// Directed self-checking bench for mb_cycle_ctl (TO_CYCLES=64, RECOV_MIN=3).
module tb_mb_cycle_ctl;

  logic CLK = 1'b0;
  logic nRES;
  int   checks = 0;
  int   failures = 0;
  int   gap = 0;
  logic as_prev = 1'b1;
  logic        rsp_err;
  logic [31:0] rsp_data;

  always #5 CLK = ~CLK;

  mb_cycle_ctl_if bus();

  mb_cycle_ctl #(.TO_CYCLES(64), .RECOV_MIN(3)) dut (
    .CLK (CLK),
    .nRES(nRES),
    .mb  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [25:0] ca, input logic wr, input logic [31:0] wd);
    int n = 0;
    while (!bus.ReqReady && n < 50) begin tick(); n++; end
    if (!bus.ReqReady) check("req_ready_wait", 32'(bus.ReqReady), 32'd1);
    bus.ReqValid = 1'b1;
    bus.ReqCA    = ca;
    bus.ReqWrite = wr;
    bus.ReqWData = wd;
    tick();
    bus.ReqValid = 1'b0;
  endtask

  task automatic wait_as(output int n);
    n = 0;
    do begin tick(); n++; end while (bus.nMBAS && n < 20);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin tick(); n++; end while (!bus.RspValid && n < 200);
    rsp_err  = bus.RspErr;
    rsp_data = bus.RspData;
  endtask

  task automatic term(input logic [1:0] ds, input logic be, input logic [31:0] d);
    bus.nDSACK = ds;
    bus.nBERR  = be;
    bus.MBDIn  = d;
  endtask

  // Bus-level invariants: no acceptance while a cycle is busy, and a minimum AS-high gap.
  always @(negedge CLK) begin
    if (nRES && (!bus.nMBAS || bus.RspValid)) check("rdy_busy", 32'(bus.ReqReady), 32'd0);
    if (bus.nMBAS) gap++;
    else if (as_prev) begin
      check("recov_gap", 32'(gap >= 3), 32'd1);
      gap = 0;
    end
    as_prev = bus.nMBAS;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nRES = 1'b0;
    bus.ReqValid = 1'b0;
    bus.ReqCA    = '0;
    bus.ReqWrite = 1'b0;
    bus.ReqWData = '0;
    term(2'b11, 1'b1, 32'h0);
    tick(); tick();

    check("rst_ready",  32'(bus.ReqReady), 32'd0);
    check("rst_rspv",   32'(bus.RspValid), 32'd0);
    check("rst_rsperr", 32'(bus.RspErr),   32'd0);
    check("rst_rspdat", bus.RspData,       32'h0);
    check("rst_mba",    32'(bus.MBA),      32'h0);
    check("rst_rnw",    32'(bus.MBRnW),    32'd1);
    check("rst_as",     32'(bus.nMBAS),    32'd1);
    check("rst_ds",     32'(bus.nMBDS),    32'd1);
    check("rst_dout",   bus.MBDOut,        32'h0);
    check("rst_doe",    32'(bus.MBDOE),    32'd0);
    nRES = 1'b1;
    tick();
    check("idle_ready", 32'(bus.ReqReady), 32'd1);

    // VRAM read at A=0x50F00004
    issue(26'h33C0001, 1'b0, 32'h0);
    check("rd_mba",     32'(bus.MBA),   32'h143C0001);
    check("rd_rnw",     32'(bus.MBRnW), 32'd1);
    check("rd_addr_as", 32'(bus.nMBAS), 32'd1);
    check("rd_addr_oe", 32'(bus.MBDOE), 32'd0);
    wait_as(n);
    check("rd_as_lat",  32'(n),         32'd1);
    check("rd_ds",      32'(bus.nMBDS), 32'd0);
    tick(); tick(); tick();
    term(2'b00, 1'b1, 32'hDEADBEEF);
    wait_rsp(n);
    check("rd_rsp_lat", 32'(n),         32'd3);
    check("rd_data",    rsp_data,       32'hDEADBEEF);
    check("rd_err",     32'(rsp_err),   32'd0);
    check("rd_rsp_as",  32'(bus.nMBAS), 32'd1);
    check("rd_rsp_ds",  32'(bus.nMBDS), 32'd1);
    term(2'b11, 1'b1, 32'h0);
    tick();
    check("rd_pulse",   32'(bus.RspValid), 32'd0);

    // ROM write at A=0x40000000
    issue(26'h2000000, 1'b1, 32'h12345678);
    check("wr_mba",     32'(bus.MBA),   32'h10000000);
    check("wr_rnw",     32'(bus.MBRnW), 32'd0);
    check("wr_addr_oe", 32'(bus.MBDOE), 32'd1);
    check("wr_dout",    bus.MBDOut,     32'h12345678);
    wait_as(n);
    check("wr_as_lat",  32'(n),         32'd1);
    check("wr_ds_late", 32'(bus.nMBDS), 32'd1);
    tick();
    check("wr_ds",      32'(bus.nMBDS), 32'd0);
    term(2'b00, 1'b1, 32'h0);
    wait_rsp(n);
    check("wr_err",     32'(rsp_err),   32'd0);
    check("wr_doe_off", 32'(bus.MBDOE), 32'd0);
    check("wr_data_hold", rsp_data,     32'hDEADBEEF);
    term(2'b11, 1'b1, 32'h0);

    // RAM read with no termination -> timeout
    issue(26'h1ABCDEF, 1'b0, 32'h0);
    check("to_mba",     32'(bus.MBA),   32'h04ABCDEF);
    wait_as(n);
    wait_rsp(n);
    check("to_lat",     32'(n),         32'd64);
    check("to_err",     32'(rsp_err),   32'd1);
    check("to_as",      32'(bus.nMBAS), 32'd1);
    check("to_ds",      32'(bus.nMBDS), 32'd1);
    check("to_data",    rsp_data,       32'hDEADBEEF);

    // BERR together with DSACK=00: error wins, data still captured
    issue(26'h0000010, 1'b0, 32'h0);
    wait_as(n);
    term(2'b00, 1'b0, 32'hCAFEF00D);
    wait_rsp(n);
    check("be_err",     32'(rsp_err),   32'd1);
    check("be_data",    rsp_data,       32'hCAFEF00D);
    term(2'b11, 1'b1, 32'h0);
    tick();
    check("be_err_clr", 32'(bus.RspErr), 32'd0);

    // 8-bit port ack -> error, no capture; DSACK held keeps the FSM out of IDLE
    issue(26'h0000020, 1'b0, 32'h0);
    wait_as(n);
    term(2'b10, 1'b1, 32'h11111111);
    wait_rsp(n);
    check("nw_err",     32'(rsp_err),   32'd1);
    check("nw_data",    rsp_data,       32'hCAFEF00D);
    for (int i = 0; i < 10; i++) tick();
    check("hold_ready", 32'(bus.ReqReady), 32'd0);
    term(2'b11, 1'b1, 32'h0);
    n = 0;
    do begin tick(); n++; end while (!bus.ReqReady && n < 20);
    check("rel_lat",    32'(n),         32'd3);

    // Reset during STRB of a write
    issue(26'h0000030, 1'b1, 32'hA5A5A5A5);
    wait_as(n);
    tick();
    nRES = 1'b0;
    #1;
    check("ar_as",      32'(bus.nMBAS), 32'd1);
    check("ar_doe",     32'(bus.MBDOE), 32'd0);
    check("ar_ds",      32'(bus.nMBDS), 32'd1);
    tick(); tick();
    nRES = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (bus.RspValid) n++; end
    check("ar_no_rsp",  32'(n),         32'd0);
    issue(26'h0000040, 1'b0, 32'h0);
    wait_as(n);
    term(2'b00, 1'b1, 32'h0BADF00D);
    wait_rsp(n);
    check("ar_next_err",  32'(rsp_err), 32'd0);
    check("ar_next_data", rsp_data,     32'h0BADF00D);
    term(2'b11, 1'b1, 32'h0);

    // Back-to-back reads; the monitor checks the AS-high gap
    issue(26'h0000050, 1'b0, 32'h0);
    wait_as(n);
    term(2'b00, 1'b1, 32'h01020304);
    wait_rsp(n);
    check("b2b1_data",  rsp_data,       32'h01020304);
    term(2'b11, 1'b1, 32'h0);
    issue(26'h0000054, 1'b0, 32'h0);
    check("b2b2_mba",   32'(bus.MBA),   32'h00000054);
    wait_as(n);
    term(2'b00, 1'b1, 32'h05060708);
    wait_rsp(n);
    check("b2b2_data",  rsp_data,       32'h05060708);
    check("b2b2_err",   32'(rsp_err),   32'd0);
    term(2'b11, 1'b1, 32'h0);
    for (int i = 0; i < 6; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
